// File: rtl/clk_en_sched_pkg.sv
// Shared types and constants for the clk_en_sched clock-enable scheduler.
// Pending-request fields use fixed maximum widths so the type is parameter-free.
package clk_en_sched_pkg;

  localparam int C_MAX_CH_WIDTH  = 4;
  localparam int C_MAX_DIV_WIDTH = 32;
  localparam int C_DIV_DISABLE   = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [C_MAX_CH_WIDTH-1:0]  ch;
    logic [C_MAX_DIV_WIDTH-1:0] div;
  } pend_req_t;

  localparam pend_req_t C_PEND_RST = '{ch: {C_MAX_CH_WIDTH{1'b0}}, div: {C_MAX_DIV_WIDTH{1'b0}}};

  function automatic int ch_width_f(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_en_sched_if.sv
// Run-time configuration port of clk_en_sched: valid/ready request plus error pulse.
interface clk_en_sched_if #(
  parameter int C_NUM_CH    = 4,
  parameter int C_DIV_WIDTH = 8
);
  import clk_en_sched_pkg::*;

  localparam int C_CH_WIDTH = ch_width_f(C_NUM_CH);

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [C_CH_WIDTH-1:0]  cfg_ch;
  logic [C_DIV_WIDTH-1:0] cfg_div;
  logic                   cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/clk_en_chan.sv
// One divided clock-enable channel: down-counter reloaded from div at every strobe.
// With CLK_EN_SCHED_SYNC_EN defined, sync_i re-phases an active channel to cnt=div-1.
module clk_en_chan
  import clk_en_sched_pkg::*;
#(
  parameter int C_DIV_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [C_DIV_WIDTH-1:0] div_i,
`ifdef CLK_EN_SCHED_SYNC_EN
  input  logic                   sync_i,
`endif
  output logic                   ce_o,
  output logic                   active_o
);

  localparam logic [C_DIV_WIDTH-1:0] C_ZERO = C_DIV_WIDTH'(0);
  localparam logic [C_DIV_WIDTH-1:0] C_ONE  = C_DIV_WIDTH'(1);
  localparam logic [C_DIV_WIDTH-1:0] C_OFF  = C_DIV_WIDTH'(C_DIV_DISABLE);

  logic [C_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_DIV_WIDTH-1:0] div_q, div_d;
  logic                   active_q, active_d;

  // Next-state: an explicit load wins over re-phasing, which wins over free running.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    active_d = active_q;
    if (load_i) begin
      if (div_i == C_OFF) begin
        active_d = 1'b0;
        cnt_d    = C_ZERO;
        div_d    = C_ZERO;
      end else begin
        active_d = 1'b1;
        cnt_d    = div_i - C_ONE;
        div_d    = div_i;
      end
    end
`ifdef CLK_EN_SCHED_SYNC_EN
    else if (sync_i && active_q) begin
      cnt_d = div_q - C_ONE;
    end
`endif
    else if (active_q) begin
      if (cnt_q == C_ZERO) begin
        cnt_d = div_q - C_ONE;
      end else begin
        cnt_d = cnt_q - C_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= C_ZERO;
      div_q    <= C_ZERO;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      active_q <= active_d;
    end
  end

  assign ce_o     = active_q & (cnt_q == C_ZERO);
  assign active_o = active_q;

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: C_NUM_CH divided strobes off one clock, reconfigured at period boundaries.
// Optional macro CLK_EN_SCHED_SYNC_EN adds sync_i to phase-align all active channels.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int C_NUM_CH    = 4,
  parameter int C_DIV_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  clk_en_sched_if.slave       cfg,
  output logic [C_NUM_CH-1:0] ce_out,
  output logic [C_NUM_CH-1:0] ch_active,
  output logic                busy
`ifdef CLK_EN_SCHED_SYNC_EN
  ,
  input  logic                sync_i
`endif
);

  localparam int C_CH_WIDTH = ch_width_f(C_NUM_CH);
  localparam logic [C_CH_WIDTH:0]    C_NUM_CH_V = (C_CH_WIDTH+1)'(C_NUM_CH);
  localparam logic [C_DIV_WIDTH-1:0] C_OFF      = C_DIV_WIDTH'(C_DIV_DISABLE);

  sched_state_e           state_q, state_d;
  pend_req_t              pend_q, pend_d;
  logic                   err_q, err_d;
  logic                   ready_s;
  logic                   xfer_s;
  logic                   in_range_s;
  logic                   tgt_active_s;
  logic                   pend_off_s;
  logic                   boundary_s;
  logic [C_NUM_CH-1:0]    start_sel_s;
  logic [C_NUM_CH-1:0]    pend_hit_s;
  logic [C_NUM_CH-1:0]    load_s;
  logic [C_DIV_WIDTH-1:0] load_div_s;

  assign ready_s      = (state_q == ST_IDLE);
  assign xfer_s       = cfg.cfg_valid & ready_s;
  assign in_range_s   = ({1'b0, cfg.cfg_ch} < C_NUM_CH_V);
  assign tgt_active_s = |(start_sel_s & ch_active);
  assign pend_off_s   = (pend_q.div == C_MAX_DIV_WIDTH'(C_DIV_DISABLE));

  // Only one load source is live at a time: the pending request in WAIT, the port in IDLE.
  assign load_div_s = (state_q == ST_WAIT)
                    ? (pend_off_s ? C_OFF : pend_q.div[C_DIV_WIDTH-1:0])
                    : cfg.cfg_div;

`ifdef CLK_EN_SCHED_SYNC_EN
  assign boundary_s = (|(pend_hit_s & ce_out)) | sync_i;
`else
  assign boundary_s = |(pend_hit_s & ce_out);
`endif

  // FSM next-state, pending capture and per-channel load strobes.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    load_s  = {C_NUM_CH{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (xfer_s && !in_range_s) begin
          err_d = 1'b1;
        end else if (xfer_s && tgt_active_s) begin
          pend_d.ch  = C_MAX_CH_WIDTH'(cfg.cfg_ch);
          pend_d.div = C_MAX_DIV_WIDTH'(cfg.cfg_div);
          state_d    = ST_WAIT;
        end else if (xfer_s && (cfg.cfg_div != C_OFF)) begin
          load_s = start_sel_s;
        end else begin
          load_s = {C_NUM_CH{1'b0}};
        end
      end
      ST_WAIT: begin
        if (boundary_s) begin
          load_s  = pend_hit_s;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, pending request and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= C_PEND_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    assign start_sel_s[i] = (cfg.cfg_ch == C_CH_WIDTH'(i));
    assign pend_hit_s[i]  = (pend_q.ch == C_MAX_CH_WIDTH'(i));

    clk_en_chan #(
      .C_DIV_WIDTH(C_DIV_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load_s[i]),
      .div_i    (load_div_s),
`ifdef CLK_EN_SCHED_SYNC_EN
      .sync_i   (sync_i),
`endif
      .ce_o     (ce_out[i]),
      .active_o (ch_active[i])
    );
  end

  assign cfg.cfg_ready = ready_s;
  assign cfg.cfg_err   = err_q;
  assign busy          = ~ready_s;

endmodule

// File: tb/tb_clk_en_sched.sv
// Bench for clk_en_sched: directed and random config traffic against a model that tracks
// each channel's period and the absolute edge of its next strobe.
module tb_clk_en_sched;
  import clk_en_sched_pkg::*;

  localparam int NCH = 5;   // five channels so that cfg_ch 5..7 is out of range
  localparam int DW  = 8;
  localparam int CW  = ch_width_f(NCH);
  localparam int VW  = 2*NCH + 3;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] ce_out;
  logic [NCH-1:0] ch_active;
  logic           busy;
`ifdef CLK_EN_SCHED_SYNC_EN
  logic           sync_i = 1'b0;
`endif

  always #5 clk = ~clk;

  clk_en_sched_if #(.C_NUM_CH(NCH), .C_DIV_WIDTH(DW)) cfg_if ();

  clk_en_sched #(.C_NUM_CH(NCH), .C_DIV_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_if),
    .ce_out    (ce_out),
    .ch_active (ch_active),
    .busy      (busy)
`ifdef CLK_EN_SCHED_SYNC_EN
    ,
    .sync_i    (sync_i)
`endif
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  bit m_act [NCH];
  int m_per [NCH];
  int m_nxt [NCH];
  bit m_pend;
  int m_pch;
  int m_pdiv;
  bit m_err;

  logic [VW-1:0] dut_v;
  assign dut_v = {ce_out, ch_active, busy, cfg_if.cfg_ready, cfg_if.cfg_err};

  function automatic logic [VW-1:0] exp_v();
    logic [NCH-1:0] ce;
    logic [NCH-1:0] act;
    for (int i = 0; i < NCH; i++) begin
      ce[i]  = m_act[i] && (m_nxt[i] == edge_n);
      act[i] = m_act[i];
    end
    return {ce, act, m_pend, !m_pend, m_err};
  endfunction

  function automatic logic [VW-1:0] reset_v();
    logic [VW-1:0] v;
    v    = '0;
    v[1] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = 1'b0;
      m_per[i] = 0;
      m_nxt[i] = -10;
    end
    m_pend = 1'b0;
    m_pch  = 0;
    m_pdiv = 0;
    m_err  = 1'b0;
  endtask

  // Advance the model across one clock edge with the request seen at that edge.
  task automatic model_edge(input bit v, input int ch, input int d, input bit sy);
    bit bnd [NCH];
    bit idle;
    int e;
    edge_n++;
    e     = edge_n;
    idle  = !m_pend;
    m_err = 1'b0;
    for (int i = 0; i < NCH; i++) bnd[i] = m_act[i] && (m_nxt[i] == e - 1);
    for (int i = 0; i < NCH; i++)
      if (m_act[i] && (bnd[i] || sy)) m_nxt[i] = e + m_per[i] - 1;
    if (!idle) begin
      if (bnd[m_pch] || sy) begin
        if (m_pdiv > 0) begin
          m_per[m_pch] = m_pdiv;
          m_nxt[m_pch] = e + m_pdiv - 1;
        end else begin
          m_act[m_pch] = 1'b0;
        end
        m_pend = 1'b0;
      end
    end else if (v) begin
      if (ch >= NCH) begin
        m_err = 1'b1;
      end else if (m_act[ch]) begin
        m_pend = 1'b1;
        m_pch  = ch;
        m_pdiv = d;
      end else if (d > 0) begin
        m_act[ch] = 1'b1;
        m_per[ch] = d;
        m_nxt[ch] = e + d - 1;
      end
    end
  endtask

  task automatic cycle(input bit v, input int ch, input int d, input bit sy);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = CW'(ch);
    cfg_if.cfg_div   = DW'(d);
`ifdef CLK_EN_SCHED_SYNC_EN
    sync_i = sy;
`endif
    @(posedge clk);
    model_edge(v, ch, d, sy);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (dut_v !== reset_v()) begin
      errors++;
      $display("FAIL reset: got %b expected %b", dut_v, reset_v());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (dut_v !== exp_v()) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", dut_v, exp_v());
    end
  endtask

  task automatic test_start();
    cycle(1'b1, 0, 3, 1'b0);
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (dut_v !== exp_v()) begin
        errors++;
        $display("FAIL start_d3 cyc%0d: got %b expected %b", k, dut_v, exp_v());
      end
      cycle(1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_div1();
    cycle(1'b1, 1, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (dut_v !== exp_v() || ce_out[1] !== 1'b1) begin
        errors++;
        $display("FAIL div1 cyc%0d: got %b expected %b", k, dut_v, exp_v());
      end
      cycle(1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_defer();
    int guard;
    guard = 0;
    while (!(m_act[0] && m_nxt[0] == edge_n) && guard < 20) begin
      cycle(1'b0, 0, 0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++;
      $display("FAIL defer_wait: got no ch0 strobe within %0d cycles, required one", guard);
    end
    cycle(1'b1, 0, 5, 1'b0);
    checks++;
    if (dut_v !== exp_v() || busy !== 1'b1) begin
      errors++;
      $display("FAIL defer_accept: got %b expected %b", dut_v, exp_v());
    end
    for (int k = 0; k < 16; k++) begin
      cycle(k < 3, 2, 4, 1'b0);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++;
        $display("FAIL defer cyc%0d: got %b expected %b", k, dut_v, exp_v());
      end
    end
  endtask

  task automatic test_disable();
    cycle(1'b1, 0, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (dut_v !== exp_v()) begin
        errors++;
        $display("FAIL disable cyc%0d: got %b expected %b", k, dut_v, exp_v());
      end
      cycle(1'b0, 0, 0, 1'b0);
    end
    checks++;
    if (ch_active[0] !== 1'b0 || ce_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL disable_final: got act=%b ce=%b expected 0 0", ch_active[0], ce_out[0]);
    end
  endtask

  task automatic test_err();
    cycle(1'b1, 5, 3, 1'b0);
    checks++;
    if (dut_v !== exp_v() || cfg_if.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got %b expected %b", dut_v, exp_v());
    end
    cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (dut_v !== exp_v() || cfg_if.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected %b", dut_v, exp_v());
    end
    cycle(1'b1, 7, 1, 1'b0);
    checks++;
    if (dut_v !== exp_v()) begin
      errors++;
      $display("FAIL err_ch7: got %b expected %b", dut_v, exp_v());
    end
  endtask

  task automatic test_random();
    int r;
    int d;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      d = 0;
      else if (r == 1) d = 1;
      else if (r == 9) d = 255;
      else             d = $urandom_range(2, 7);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7), d, 1'b0);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++;
        $display("FAIL random cyc%0d: got %b expected %b", k, dut_v, exp_v());
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int guard;
    guard = 0;
    while (m_pend && guard < 300) begin
      cycle(1'b0, 0, 0, 1'b0);
      guard++;
    end
    if (m_act[3]) cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b1, 3, 0, 1'b0);
    while (m_pend && guard < 600) begin
      cycle(1'b0, 0, 0, 1'b0);
      guard++;
    end
    cycle(1'b1, 3, 200, 1'b0);
    cycle(1'b1, 3, 7, 1'b0);
    checks++;
    if (dut_v !== exp_v() || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry: got %b expected %b", dut_v, exp_v());
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_v !== reset_v()) begin
      errors++;
      $display("FAIL reset_mid_wait: got %b expected %b", dut_v, reset_v());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 0, 0, 1'b0);
    checks++;
    if (dut_v !== exp_v()) begin
      errors++;
      $display("FAIL after_reset: got %b expected %b", dut_v, exp_v());
    end
  endtask

`ifdef CLK_EN_SCHED_SYNC_EN
  task automatic test_sync();
    cycle(1'b1, 0, 2, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b1, 1, 4, 1'b0);
    cycle(1'b0, 0, 0, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (dut_v !== exp_v()) begin
        errors++;
        $display("FAIL sync cyc%0d: got %b expected %b", k, dut_v, exp_v());
      end
      cycle(1'b0, 0, 0, 1'b0);
    end
  endtask
`endif

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    model_reset();
    test_reset();
    test_start();
    test_div1();
    test_defer();
    test_disable();
    test_err();
    test_random();
    test_reset_mid_wait();
`ifdef CLK_EN_SCHED_SYNC_EN
    test_sync();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
